sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 123 ++++++++++++
 tb/tb_sync_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (first-word fall-through or registered read).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   flush      synchronous clear of pointers, count and error flags
//   winc/wdata write request and data; rejected while wfull
//   wfull      occupancy == DEPTH
//   awfull     occupancy >= AFULL_LVL
//   rinc       read request / pop; rejected while rempty
//   rdata      read data (head word in fall-through mode, popped word otherwise)
//   rempty     occupancy == 0
//   arempty    occupancy <= AEMPTY_LVL
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a write was rejected
//   underflow  sticky: a read was rejected
module sync_fifo #(
    parameter int unsigned DSIZE       = 8,
    parameter int unsigned ASIZE       = 3,
    parameter string       FALLTHROUGH = "TRUE",
    parameter int unsigned AFULL_LVL   = (1 << ASIZE) - 1,
    parameter int unsigned AEMPTY_LVL  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PW    = ASIZE + 1;
    localparam logic [PW-1:0] WRAP_C   = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);
    localparam bit FWFT = (FALLTHROUGH == "TRUE");

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    cnt;
    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] head;
    logic             wr_en;
    logic             rd_en;

    // Flags come only from registered pointers/count.
    assign wfull   = ((wptr ^ rptr) == WRAP_C);
    assign rempty  = (wptr == rptr);
    assign awfull  = (cnt >= AFULL_C);
    assign arempty = (cnt <= AEMPTY_C);
    assign count   = cnt;

    // Accepted operations; flush overrides both requests.
    assign wr_en = winc && !wfull && !flush;
    assign rd_en = rinc && !rempty && !flush;

    assign head = mem[rptr[ASIZE-1:0]];

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + PW'(1);
                2'b01:   cnt <= cnt - PW'(1);
                default: cnt <= cnt;
            endcase
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[ASIZE-1:0]] <= wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is visible while non-empty; the hold register keeps the
            // last visible value so rdata is stable once the FIFO drains or flushes.
            logic [DSIZE-1:0] hold;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) hold <= '0;
                else     hold <= rdata;
            end
            assign rdata = rempty ? hold : head;
        end else begin : g_reg
            // Popped word is captured on the edge that accepts the read.
            logic [DSIZE-1:0] rd_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        rd_q <= '0;
                else if (rd_en) rd_q <= head;
            end
            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one fall-through and one registered-read
// instance share the same stimulus; expected values are hand-derived.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;

    logic       f_wfull, f_awfull, f_rempty, f_arempty, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [3:0] f_count;
    logic       r_wfull, r_awfull, r_rempty, r_arempty, r_ovf, r_unf;
    logic [7:0] r_rdata;
    logic [3:0] r_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FALLTHROUGH("TRUE"),
                .AFULL_LVL(6), .AEMPTY_LVL(1)) u_ft (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata),
        .wfull(f_wfull), .awfull(f_awfull), .rinc(rinc), .rdata(f_rdata),
        .rempty(f_rempty), .arempty(f_arempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FALLTHROUGH("FALSE"),
                .AFULL_LVL(6), .AEMPTY_LVL(1)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata),
        .wfull(r_wfull), .awfull(r_awfull), .rinc(rinc), .rdata(r_rdata),
        .rempty(r_rempty), .arempty(r_arempty), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs set at negedge take effect on the following posedge;
    // outputs are sampled at the next negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        #2;
        chk("rst_count",   32'(f_count),   32'(0));
        chk("rst_rempty",  32'(f_rempty),  32'(1));
        chk("rst_arempty", 32'(f_arempty), 32'(1));
        chk("rst_wfull",   32'(f_wfull),   32'(0));
        chk("rst_awfull",  32'(f_awfull),  32'(0));
        chk("rst_ovf",     32'(f_ovf),     32'(0));
        chk("rst_unf",     32'(f_unf),     32'(0));
        chk("rst_rdata_f", 32'(f_rdata),   32'(0));
        chk("rst_rdata_r", 32'(r_rdata),   32'(0));
        chk("rst_r_count", 32'(r_count),   32'(0));
        chk("rst_r_flags", 32'({r_wfull, r_awfull, r_rempty, r_arempty, r_ovf, r_unf}),
            32'(6'b001100));
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1; wdata = 8'(8'h11 + i);
            cyc();
            chk("fill_count",   32'(f_count),   32'(i + 1));
            chk("fill_awfull",  32'(f_awfull),  32'((i + 1) >= 6));
            chk("fill_wfull",   32'(f_wfull),   32'((i + 1) == 8));
            chk("fill_arempty", 32'(f_arempty), 32'((i + 1) <= 1));
            chk("fill_rempty",  32'(f_rempty),  32'(0));
            chk("fill_head_f",  32'(f_rdata),   32'(8'h11));
        end
        chk("fill_rdata_r", 32'(r_rdata), 32'(0));

        // Write while full is rejected
        wdata = 8'hAA;
        cyc();
        winc = 1'b0;
        chk("ovf_flag",  32'(f_ovf),   32'(1));
        chk("ovf_count", 32'(f_count), 32'(8));
        chk("ovf_wfull", 32'(f_wfull), 32'(1));

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk("drain_head_f", 32'(f_rdata), 32'(8'h11 + i));
            rinc = 1'b1;
            cyc();
            chk("drain_rdata_r", 32'(r_rdata),   32'(8'h11 + i));
            chk("drain_count",   32'(f_count),   32'(7 - i));
            chk("drain_arempty", 32'(f_arempty), 32'((7 - i) <= 1));
            chk("drain_rempty",  32'(f_rempty),  32'(i == 7));
        end
        chk("drain_hold_f", 32'(f_rdata), 32'(8'h18));

        // Read while empty is rejected
        cyc();
        rinc = 1'b0;
        chk("unf_flag",  32'(f_unf),   32'(1));
        chk("unf_count", 32'(f_count), 32'(0));
        chk("unf_ovf",   32'(f_ovf),   32'(1));

        // Flush clears flags, ignores winc, keeps rdata
        flush = 1'b1; winc = 1'b1; wdata = 8'h77;
        cyc();
        flush = 1'b0; winc = 1'b0;
        chk("flush_ovf",     32'(f_ovf),    32'(0));
        chk("flush_unf",     32'(f_unf),    32'(0));
        chk("flush_count",   32'(f_count),  32'(0));
        chk("flush_rempty",  32'(f_rempty), 32'(1));
        chk("flush_rdata_f", 32'(f_rdata),  32'(8'h18));
        chk("flush_rdata_r", 32'(r_rdata),  32'(8'h18));

        // Simultaneous at empty: write accepted, read rejected
        winc = 1'b1; rinc = 1'b1; wdata = 8'h21;
        cyc();
        rinc = 1'b0;
        chk("simE_count",  32'(f_count), 32'(1));
        chk("simE_unf",    32'(f_unf),   32'(1));
        chk("simE_head_f", 32'(f_rdata), 32'(8'h21));
        for (int i = 1; i < 8; i++) begin
            wdata = 8'(8'h21 + i);
            cyc();
        end
        chk("simF_pre_count", 32'(f_count), 32'(8));

        // Simultaneous at full: read accepted, write rejected
        rinc = 1'b1; wdata = 8'h99;
        cyc();
        winc = 1'b0; rinc = 1'b0;
        chk("simF_count",   32'(f_count), 32'(7));
        chk("simF_ovf",     32'(f_ovf),   32'(1));
        chk("simF_rdata_r", 32'(r_rdata), 32'(8'h21));
        chk("simF_head_f",  32'(f_rdata), 32'(8'h22));

        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Steady state at count 4 across pointer wrap
        winc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(8'h30 + i);
            cyc();
        end
        rinc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wdata = 8'(8'h34 + k);
            chk("steady_head_f", 32'(f_rdata), 32'(8'h30 + k));
            cyc();
            chk("steady_count",   32'(f_count), 32'(4));
            chk("steady_rdata_r", 32'(r_rdata), 32'(8'h30 + k));
        end
        winc = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("tail_rdata_r", 32'(r_rdata), 32'(8'h44 + j));
        end
        rinc = 1'b0;
        chk("tail_rempty", 32'(f_rempty), 32'(1));

        // Mode check: fall-through shows data one cycle after write
        winc = 1'b1; wdata = 8'h5C;
        cyc();
        winc = 1'b0;
        chk("mode_ft_rdata",  32'(f_rdata),  32'(8'h5C));
        chk("mode_ft_rempty", 32'(f_rempty), 32'(0));
        chk("mode_reg_hold",  32'(r_rdata),  32'(8'h47));
        rinc = 1'b1;
        cyc();
        rinc = 1'b0;
        chk("mode_reg_rdata", 32'(r_rdata),  32'(8'h5C));
        chk("mode_rempty",    32'(f_rempty), 32'(1));

        // Reset mid-stream at count 5
        winc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'(8'h61 + i);
            cyc();
        end
        winc = 1'b0;
        chk("mid_pre_count", 32'(f_count), 32'(5));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count",  32'(f_count),  32'(0));
        chk("mid_rst_rempty", 32'(f_rempty), 32'(1));
        chk("mid_rst_rdata",  32'(f_rdata),  32'(0));
        chk("mid_rst_wfull",  32'(f_wfull),  32'(0));
        @(negedge clk);
        rst = 1'b0;
        winc = 1'b1; wdata = 8'h3D;
        cyc();
        winc = 1'b0;
        chk("post_rst_count",   32'(f_count), 32'(1));
        chk("post_rst_rdata_f", 32'(f_rdata), 32'(8'h3D));
        rinc = 1'b1;
        cyc();
        rinc = 1'b0;
        chk("post_rst_rdata_r", 32'(r_rdata),  32'(8'h3D));
        chk("post_rst_rempty",  32'(f_rempty), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
